// File: rtl/request_latch_pkg.sv
//------------------------------------------------------------------------------
// Module   : request_latch_pkg
// Brief    : Shared channel-count constant and channel-index type for the
//            request latch and its downstream priority encoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package request_latch_pkg;

    localparam int N_REQ_MAX = 4;

    typedef logic [1:0] req_idx_t;

endpackage : request_latch_pkg

`default_nettype wire

// File: rtl/request_latch_key_debounce.sv
//------------------------------------------------------------------------------
// Module   : key_debounce
// Brief    : One push-button channel. It synchronises the key, optionally
//            debounces it (REQUEST_LATCH_DEBOUNCE_EN) and emits a one-cycle
//            pulse on each accepted 0->1 transition.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
    import request_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable_d;
    logic w_stable;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYCLES out of range");
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
        end
    end

`ifdef REQUEST_LATCH_DEBOUNCE_EN
    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stable;

    // The counter tops out at DEBOUNCE_CYCLES-1: the next disagreeing cycle
    // flips the level and clears it, so it can never wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_sync2;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    assign rise = w_stable & ~r_stable_d;

endmodule : key_debounce

`default_nettype wire

// File: rtl/request_latch.sv
//------------------------------------------------------------------------------
// Module   : request_latch
// Brief    : Turns N_REQ bouncing push-buttons into sticky request lines with
//            per-channel acknowledge and sticky overrun flags. Debouncing is
//            enabled by defining REQUEST_LATCH_DEBOUNCE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module request_latch
    import request_latch_pkg::*;
#(
    parameter int N_REQ           = 3,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] key,
    input  logic             ack,
    input  logic [1:0]       ack_idx,
    output logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] overrun
);

    logic [N_REQ-1:0] w_rise;
    logic [N_REQ-1:0] w_clr;

    if (N_REQ < 1 || N_REQ > N_REQ_MAX) begin : g_param_check
        $error("request_latch: N_REQ out of range");
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_chan
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clock (clock),
            .reset (reset),
            .key   (key[i]),
            .rise  (w_rise[i])
        );

        // Only indices below N_REQ have a channel, so out-of-range acks decode to nothing.
        assign w_clr[i] = ack && (req_idx_t'(ack_idx) == req_idx_t'(i));

        // A new press beats a same-cycle clear so that no press is lost.
        always_ff @(posedge clock) begin
            if (reset) begin
                req[i]     <= 1'b0;
                overrun[i] <= 1'b0;
            end else if (w_rise[i]) begin
                req[i] <= 1'b1;
                if (req[i] && !w_clr[i]) begin
                    overrun[i] <= 1'b1;
                end
            end else if (w_clr[i]) begin
                req[i] <= 1'b0;
            end
        end
    end

endmodule : request_latch

`default_nettype wire

// File: tb/tb_request_latch.sv
//------------------------------------------------------------------------------
// Module   : tb_request_latch
// Brief    : Directed self-checking bench for request_latch (N_REQ=3,
//            DEBOUNCE_CYCLES=4), covering both REQUEST_LATCH_DEBOUNCE_EN builds.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_request_latch;

    localparam int N_REQ = 3;
    localparam int D     = 4;
`ifdef REQUEST_LATCH_DEBOUNCE_EN
    localparam int LAT   = D + 3;
`else
    localparam int LAT   = 3;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [N_REQ-1:0] key;
    logic             ack;
    logic [1:0]       ack_idx;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] overrun;

    int errors = 0;
    int checks = 0;

    request_latch #(
        .N_REQ           (N_REQ),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .key     (key),
        .ack     (ack),
        .ack_idx (ack_idx),
        .req     (req),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; key = '0; ack = 1'b0; ack_idx = 2'd0;
        tick(2);
        reset = 1'b0;
        checks++;
        if (req !== 3'b000) begin $display("FAIL reset_req got=%b exp=%b", req, 3'b000); errors++; end
        checks++;
        if (overrun !== 3'b000) begin $display("FAIL reset_ovr got=%b exp=%b", overrun, 3'b000); errors++; end
    endtask

    task automatic test_latency();
        key = 3'b001;
        tick(LAT - 1);
        checks++;
        if (req !== 3'b000) begin $display("FAIL lat_early got=%b exp=%b", req, 3'b000); errors++; end
        tick(1);
        checks++;
        if (req !== 3'b001) begin $display("FAIL lat_req got=%b exp=%b", req, 3'b001); errors++; end
        checks++;
        if (overrun !== 3'b000) begin $display("FAIL lat_ovr got=%b exp=%b", overrun, 3'b000); errors++; end
        key = 3'b000;
        tick(LAT + 2);
        checks++;
        if (req !== 3'b001) begin $display("FAIL release_sticky got=%b exp=%b", req, 3'b001); errors++; end
        ack = 1'b1; ack_idx = 2'd0;
        tick(1);
        ack = 1'b0;
        checks++;
        if (req !== 3'b000) begin $display("FAIL ack0_clear got=%b exp=%b", req, 3'b000); errors++; end
    endtask

`ifdef REQUEST_LATCH_DEBOUNCE_EN
    task automatic test_bounce();
        logic [3:0] pat = 4'b0111;
        logic       leak = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 4; b++) begin
                key = {1'b0, pat[b], 1'b0};
                tick(1);
                if (req !== 3'b000) leak = 1'b1;
            end
        end
        checks++;
        if (leak !== 1'b0) begin $display("FAIL bounce_leak got=%b exp=%b", leak, 1'b0); errors++; end
        key = 3'b010;
        tick(LAT - 1);
        checks++;
        if (req !== 3'b000) begin $display("FAIL bounce_early got=%b exp=%b", req, 3'b000); errors++; end
        tick(1);
        checks++;
        if (req !== 3'b010) begin $display("FAIL bounce_hold got=%b exp=%b", req, 3'b010); errors++; end
        key = 3'b000;
        tick(LAT + 2);
        ack = 1'b1; ack_idx = 2'd1;
        tick(1);
        ack = 1'b0;
        checks++;
        if (req !== 3'b000) begin $display("FAIL bounce_ack got=%b exp=%b", req, 3'b000); errors++; end
    endtask
`else
    task automatic test_glitch();
        key = 3'b100;
        tick(1);
        key = 3'b000;
        tick(1);
        checks++;
        if (req !== 3'b000) begin $display("FAIL glitch_early got=%b exp=%b", req, 3'b000); errors++; end
        tick(1);
        checks++;
        if (req !== 3'b100) begin $display("FAIL glitch_latch got=%b exp=%b", req, 3'b100); errors++; end
        tick(3);
        ack = 1'b1; ack_idx = 2'd2;
        tick(1);
        ack = 1'b0;
        checks++;
        if (req !== 3'b000) begin $display("FAIL glitch_ack got=%b exp=%b", req, 3'b000); errors++; end
    endtask
`endif

    task automatic test_ack();
        key = 3'b111;
        tick(LAT);
        checks++;
        if (req !== 3'b111) begin $display("FAIL all_set got=%b exp=%b", req, 3'b111); errors++; end
        key = 3'b000;
        tick(LAT + 2);
        ack = 1'b1; ack_idx = 2'd2;
        tick(1);
        checks++;
        if (req !== 3'b011) begin $display("FAIL ack2 got=%b exp=%b", req, 3'b011); errors++; end
        ack_idx = 2'd3;
        tick(1);
        checks++;
        if (req !== 3'b011) begin $display("FAIL ack3_ignored got=%b exp=%b", req, 3'b011); errors++; end
        ack = 1'b0; ack_idx = 2'd1;
        tick(1);
        checks++;
        if (req !== 3'b011) begin $display("FAIL ack_low_ignored got=%b exp=%b", req, 3'b011); errors++; end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++;
        if (req !== 3'b001) begin $display("FAIL ack1_indep got=%b exp=%b", req, 3'b001); errors++; end
    endtask

    task automatic test_set_wins();
        key = 3'b001;
        tick(LAT - 1);
        ack = 1'b1; ack_idx = 2'd0;
        tick(1);
        ack = 1'b0;
        checks++;
        if (req !== 3'b001) begin $display("FAIL setwin_req got=%b exp=%b", req, 3'b001); errors++; end
        checks++;
        if (overrun !== 3'b000) begin $display("FAIL setwin_ovr got=%b exp=%b", overrun, 3'b000); errors++; end
        key = 3'b000;
        tick(LAT + 2);
        key = 3'b001;
        tick(LAT + 1);
        checks++;
        if (overrun !== 3'b001) begin $display("FAIL overrun_set got=%b exp=%b", overrun, 3'b001); errors++; end
        checks++;
        if (req !== 3'b001) begin $display("FAIL overrun_req got=%b exp=%b", req, 3'b001); errors++; end
        key = 3'b000;
        tick(LAT + 2);
        ack = 1'b1; ack_idx = 2'd0;
        tick(1);
        ack = 1'b0;
        checks++;
        if (req !== 3'b000) begin $display("FAIL overrun_ack_req got=%b exp=%b", req, 3'b000); errors++; end
        checks++;
        if (overrun !== 3'b001) begin $display("FAIL overrun_sticky got=%b exp=%b", overrun, 3'b001); errors++; end
    endtask

    task automatic test_reset_mid();
        key = 3'b101;
        tick(LAT);
        checks++;
        if (req !== 3'b101) begin $display("FAIL pre_reset_req got=%b exp=%b", req, 3'b101); errors++; end
        key = 3'b010;
        tick(4);
        reset = 1'b1;
        tick(1);
        checks++;
        if (req !== 3'b000) begin $display("FAIL mid_reset_req got=%b exp=%b", req, 3'b000); errors++; end
        checks++;
        if (overrun !== 3'b000) begin $display("FAIL mid_reset_ovr got=%b exp=%b", overrun, 3'b000); errors++; end
        reset = 1'b0;
        tick(LAT - 1);
        checks++;
        if (req !== 3'b000) begin $display("FAIL post_reset_early got=%b exp=%b", req, 3'b000); errors++; end
        tick(1);
        checks++;
        if (req !== 3'b010) begin $display("FAIL post_reset_req got=%b exp=%b", req, 3'b010); errors++; end
    endtask

    initial begin
        test_reset();
        test_latency();
`ifdef REQUEST_LATCH_DEBOUNCE_EN
        test_bounce();
`else
        test_glitch();
`endif
        test_ack();
        test_set_wins();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_request_latch

`default_nettype wire
